// File: rtl/i2c_reg_slave_if.sv
// Bundle of the I2C pad signals and the external register-bank port.
// The slave modport is the target's view; master is the bus/bank side.
interface i2c_reg_slave_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       txn_done;

  modport slave (
    input  scl_in, sda_in, reg_rdata,
    output sda_oe, reg_addr, reg_wdata, reg_we, reg_rd, busy, txn_done
  );

  modport master (
    output scl_in, sda_in, reg_rdata,
    input  sda_oe, reg_addr, reg_wdata, reg_we, reg_rd, busy, txn_done
  );
endinterface

// File: rtl/i2c_reg_slave.sv
// I2C target with an 8-bit register pointer; register storage sits outside
// and is reached through a write strobe / read request port.
module i2c_reg_slave #(
  parameter logic [6:0] CHIP_ADDR  = 7'h39,
  parameter int         FILTER_LEN = 3
) (
  input  logic         clk,
  input  logic         reset,
  i2c_reg_slave_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_STOP
  } state_t;

  // Per-line synchronizer plus run-length filter: bit 0 = SCL, bit 1 = SDA.
  logic [1:0] raw_in;
  logic [1:0] filt;
  logic [1:0] filt_d_reg;

  assign raw_in = {bus.sda_in, bus.scl_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_in
      logic [1:0]            sync_reg;
      logic [FILTER_LEN-1:0] hist_reg;
      logic                  filt_bit_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          sync_reg     <= '1;
          hist_reg     <= '1;
          filt_bit_reg <= 1'b1;
        end else begin
          sync_reg <= {sync_reg[0], raw_in[gi]};
          hist_reg <= FILTER_LEN'({hist_reg, sync_reg[1]});
          if (&hist_reg)
            filt_bit_reg <= 1'b1;
          else if (~|hist_reg)
            filt_bit_reg <= 1'b0;
        end
      end

      assign filt[gi] = filt_bit_reg;
    end
  endgenerate

  logic scl_f, sda_f, scl_d, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_f     = filt[0];
  assign sda_f     = filt[1];
  assign scl_d     = filt_d_reg[0];
  assign sda_d     = filt_d_reg[1];
  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  // SCL must be steady high across both samples, so a simultaneous SCL edge never qualifies.
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

  state_t     state_reg, state_next;
  logic [3:0] bit_cnt_reg, bit_cnt_next;
  logic [6:0] shift_reg, shift_next;
  logic [7:0] tx_reg, tx_next;
  logic [7:0] ptr_reg, ptr_next;
  logic       rw_reg, rw_next;
  logic       sda_oe_reg, sda_oe_next;
  logic [7:0] reg_addr_reg, reg_addr_next;
  logic [7:0] reg_wdata_reg, reg_wdata_next;
  logic       reg_we_reg, reg_we_next;
  logic       reg_rd_reg, reg_rd_next;
  logic       busy_reg, busy_next;
  logic       txn_done_reg, txn_done_next;
  logic       rd_pipe_reg;

  logic [7:0] shift_in;
  logic [2:0] tx_idx;

  assign shift_in = {shift_reg, sda_f};
  assign tx_idx   = 3'd7 - bit_cnt_reg[2:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_d_reg    <= 2'b11;
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      tx_reg        <= '0;
      ptr_reg       <= '0;
      rw_reg        <= 1'b0;
      sda_oe_reg    <= 1'b0;
      reg_addr_reg  <= '0;
      reg_wdata_reg <= '0;
      reg_we_reg    <= 1'b0;
      reg_rd_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      txn_done_reg  <= 1'b0;
      rd_pipe_reg   <= 1'b0;
    end else begin
      filt_d_reg    <= filt;
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      tx_reg        <= tx_next;
      ptr_reg       <= ptr_next;
      rw_reg        <= rw_next;
      sda_oe_reg    <= sda_oe_next;
      reg_addr_reg  <= reg_addr_next;
      reg_wdata_reg <= reg_wdata_next;
      reg_we_reg    <= reg_we_next;
      reg_rd_reg    <= reg_rd_next;
      busy_reg      <= busy_next;
      txn_done_reg  <= txn_done_next;
      rd_pipe_reg   <= reg_rd_reg;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    ptr_next       = ptr_reg;
    rw_next        = rw_reg;
    sda_oe_next    = sda_oe_reg;
    reg_addr_next  = reg_addr_reg;
    reg_wdata_next = reg_wdata_reg;
    reg_we_next    = 1'b0;
    reg_rd_next    = 1'b0;
    busy_next      = busy_reg;
    txn_done_next  = 1'b0;
    // Read data arrives two cycles after the request.
    tx_next        = rd_pipe_reg ? bus.reg_rdata : tx_reg;

    if (stop_det) begin
      state_next    = IDLE;
      bit_cnt_next  = '0;
      sda_oe_next   = 1'b0;
      busy_next     = 1'b0;
      txn_done_next = busy_reg;
    end else if (start_det) begin
      state_next   = ADDR;
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
    end else begin
      case (state_reg)
        ADDR, PTR, WR: begin
          if (scl_rise) begin
            shift_next   = shift_in[6:0];
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd7) begin
              if (state_reg == ADDR) begin
                if (shift_in[7:1] == CHIP_ADDR) begin
                  state_next = ADDR_ACK;
                  busy_next  = 1'b1;
                  rw_next    = shift_in[0];
                end else begin
                  state_next = WAIT_STOP;
                end
              end else if (state_reg == PTR) begin
                ptr_next      = shift_in;
                reg_addr_next = shift_in;
                state_next    = PTR_ACK;
              end else begin
                reg_wdata_next = shift_in;
                reg_addr_next  = ptr_reg;
                reg_we_next    = 1'b1;
                ptr_next       = ptr_reg + 8'd1;
                state_next     = WR_ACK;
              end
            end
          end
        end
        ADDR_ACK, PTR_ACK, WR_ACK: begin
          if (scl_fall && bit_cnt_reg == 4'd8) begin
            sda_oe_next = 1'b1;
          end else if (scl_rise) begin
            bit_cnt_next = 4'd9;
            if (state_reg == ADDR_ACK && rw_reg) begin
              reg_rd_next   = 1'b1;
              reg_addr_next = ptr_reg;
            end
          end else if (scl_fall && bit_cnt_reg == 4'd9) begin
            bit_cnt_next = '0;
            if (state_reg == ADDR_ACK && rw_reg) begin
              state_next  = RD;
              sda_oe_next = ~tx_reg[7];
            end else begin
              sda_oe_next = 1'b0;
              state_next  = (state_reg == ADDR_ACK) ? PTR : WR;
            end
          end
        end
        RD: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_reg == 4'd8) begin
              sda_oe_next = 1'b0;
              state_next  = RD_ACK;
            end else if (bit_cnt_reg != 4'd0) begin
              sda_oe_next = ~tx_reg[tx_idx];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise && bit_cnt_reg == 4'd8) begin
            bit_cnt_next = 4'd9;
            if (!sda_f) begin
              ptr_next      = ptr_reg + 8'd1;
              reg_addr_next = ptr_reg + 8'd1;
              reg_rd_next   = 1'b1;
            end else begin
              state_next = WAIT_STOP;
              busy_next  = 1'b0;
            end
          end else if (scl_fall && bit_cnt_reg == 4'd9) begin
            bit_cnt_next = '0;
            state_next   = RD;
            sda_oe_next  = ~tx_reg[7];
          end
        end
        WAIT_STOP: begin
          sda_oe_next = 1'b0;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign bus.sda_oe    = sda_oe_reg;
  assign bus.reg_addr  = reg_addr_reg;
  assign bus.reg_wdata = reg_wdata_reg;
  assign bus.reg_we    = reg_we_reg;
  assign bus.reg_rd    = reg_rd_reg;
  assign bus.busy      = busy_reg;
  assign bus.txn_done  = txn_done_reg;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bus-level bench for i2c_reg_slave: an I2C master model drives transactions,
// a register-map model predicts the port activity, a monitor scores it.
module tb_i2c_reg_slave;
  localparam logic [6:0] CHIP = 7'h39;
  localparam int Q = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  i2c_reg_slave_if bus();

  i2c_reg_slave #(.CHIP_ADDR(CHIP), .FILTER_LEN(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  // External register bank, reloaded with addr^0xFF on every reset.
  logic [7:0] mem [256];
  logic [7:0] rdata_q;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hFF;
      rdata_q <= 8'h00;
    end else begin
      if (bus.reg_rd) rdata_q <= mem[bus.reg_addr];
      if (bus.reg_we) mem[bus.reg_addr] <= bus.reg_wdata;
    end
  end
  assign bus.reg_rdata = rdata_q;

  // Reference model state
  logic [7:0] m_mem [256];
  logic [7:0] m_ptr;
  bit         m_busy;
  logic [7:0] wbuf [8];

  // Scoreboard queues
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  string       pn [$];
  logic [31:0] pa [$];
  logic [31:0] pe [$];
  int txn_exp  = 0;
  int txn_seen = 0;
  int checks   = 0;
  int errors   = 0;

  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, a, e);
    end
  endtask

  task automatic post(input string n, input logic [31:0] a, input logic [31:0] e);
    pn.push_back(n);
    pa.push_back(a);
    pe.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [15:0] w;
    logic [7:0]  r;
    if (bus.reg_we) begin
      if (exp_wr.size() == 0) cmp("unexpected_we", 1, 0);
      else begin
        w = exp_wr.pop_front();
        cmp("wr_addr", bus.reg_addr, w[15:8]);
        cmp("wr_data", bus.reg_wdata, w[7:0]);
      end
    end
    if (bus.reg_rd) begin
      if (exp_rd.size() == 0) cmp("unexpected_rd", 1, 0);
      else begin
        r = exp_rd.pop_front();
        cmp("rd_addr", bus.reg_addr, r);
      end
    end
    if (bus.reg_we || bus.reg_rd) cmp("we_rd_exclusive", bus.reg_we & bus.reg_rd, 0);
    if (bus.txn_done) txn_seen++;
    while (pn.size() > 0) cmp(pn.pop_front(), pa.pop_front(), pe.pop_front());
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(2*Q);
  endtask

  task automatic put_bit(input bit b, input bit glitch);
    sda_m = b; tick(Q);
    scl_m = 1'b1; tick(2*Q);
    scl_m = 1'b0;
    if (glitch) begin
      tick(3); scl_m = 1'b1; tick(1); scl_m = 1'b0; tick(Q-4);
    end else begin
      tick(Q);
    end
  endtask

  task automatic get_bit(output bit b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = bus.sda_in; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic put_byte(input logic [7:0] v, input int gl, output bit ack);
    bit b;
    for (int i = 7; i >= 0; i--) put_bit(v[i], i == gl);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic get_byte(output logic [7:0] v, input bit ack);
    bit b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
    put_bit(~ack, 1'b0);
  endtask

  task automatic txn_write(input logic [6:0] a, input logic [7:0] p, input int n,
                           input bit stop, input int gl);
    bit ack, hit;
    hit = (a == CHIP);
    $display("txn write dev=0x%0h ptr=0x%0h bytes=%0d", a, p, n);
    i2c_start(); m_busy = 0;
    put_byte({a, 1'b0}, gl, ack);
    post("addr_ack_w", ack, hit);
    if (hit) m_busy = 1;
    post("busy_after_addr", bus.busy, m_busy);
    put_byte(p, -1, ack);
    post("ptr_ack", ack, hit);
    if (hit) m_ptr = p;
    for (int i = 0; i < n; i++) begin
      if (hit) begin
        exp_wr.push_back({m_ptr, wbuf[i]});
        m_mem[m_ptr] = wbuf[i];
        m_ptr = m_ptr + 8'd1;
      end
      put_byte(wbuf[i], -1, ack);
      post("data_ack", ack, hit);
    end
    if (stop) txn_stop();
  endtask

  task automatic txn_read(input logic [6:0] a, input int n);
    bit ack, hit, last;
    logic [7:0] v, e;
    hit = (a == CHIP);
    $display("txn read  dev=0x%0h ptr=0x%0h bytes=%0d", a, m_ptr, n);
    i2c_start(); m_busy = 0;
    if (hit) exp_rd.push_back(m_ptr);
    put_byte({a, 1'b1}, -1, ack);
    post("addr_ack_r", ack, hit);
    if (hit) begin
      m_busy = 1;
      for (int i = 0; i < n; i++) begin
        last = (i == n - 1);
        e = m_mem[m_ptr];
        if (!last) exp_rd.push_back(m_ptr + 8'd1);
        get_byte(v, !last);
        post("rd_data", v, e);
        if (!last) m_ptr = m_ptr + 8'd1;
        else m_busy = 0;
      end
      post("busy_after_read", bus.busy, m_busy);
      post("sda_released", bus.sda_oe, 0);
    end
  endtask

  task automatic txn_stop();
    i2c_stop();
    if (m_busy) txn_exp++;
    m_busy = 0;
    tick(4);
    post("txn_done_count", txn_seen, txn_exp);
    post("busy_idle", bus.busy, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 8'(i) ^ 8'hFF;
    m_ptr = 8'h00;
    m_busy = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    post({tag, "_sda_oe"},    bus.sda_oe, 0);
    post({tag, "_reg_we"},    bus.reg_we, 0);
    post({tag, "_reg_rd"},    bus.reg_rd, 0);
    post({tag, "_reg_addr"},  bus.reg_addr, 0);
    post({tag, "_reg_wdata"}, bus.reg_wdata, 0);
    post({tag, "_busy"},      bus.busy, 0);
    post({tag, "_txn_done"},  bus.txn_done, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] a;
    logic [6:0] addr_pool [6];
    logic [7:0] rst_byte;
    bit ack;
    addr_pool[0] = CHIP; addr_pool[1] = CHIP; addr_pool[2] = CHIP;
    addr_pool[3] = 7'h3A; addr_pool[4] = 7'h00; addr_pool[5] = 7'h38;
    model_reset();
    tick(5);
    check_reset_outputs("rst");
    reset = 1'b0;
    tick(10);

    // Two-byte write at 0x10
    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
    txn_write(CHIP, 8'h10, 2, 1'b1, -1);

    // Pointer write, repeated START, three-byte read ending in NACK
    txn_write(CHIP, 8'h20, 0, 1'b0, -1);
    txn_read(CHIP, 3);
    txn_stop();

    // Wrong device address
    wbuf[0] = 8'h33;
    txn_write(7'h3A, 8'h44, 1, 1'b1, -1);

    // Pointer wrap
    wbuf[0] = 8'(($urandom)); wbuf[1] = 8'(($urandom));
    txn_write(CHIP, 8'hFF, 2, 1'b1, -1);

    // Reset while the address ACK is being driven
    $display("txn reset during read address ACK");
    i2c_start();
    rst_byte = {CHIP, 1'b1};
    for (int i = 7; i >= 0; i--) put_bit(rst_byte[i], 1'b0);
    sda_m = 1'b1; tick(Q);
    post("ack_before_reset", bus.sda_oe, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    tick(2);
    model_reset();
    reset = 1'b0;
    scl_m = 1'b1; sda_m = 1'b1; tick(2*Q);
    txn_read(CHIP, 2);
    txn_stop();

    // One-clock SCL glitch inside the address byte
    wbuf[0] = 8'h6C;
    txn_write(CHIP, 8'h80, 1, 1'b1, 3);

    // START in the middle of a data byte discards it
    txn_write(CHIP, 8'h42, 0, 1'b0, -1);
    $display("txn partial data byte then repeated START");
    for (int i = 0; i < 4; i++) put_bit(1'(i), 1'b0);
    txn_read(CHIP, 2);
    txn_stop();

    // Randomized mix
    for (int k = 0; k < 8; k++) begin
      a = addr_pool[$urandom_range(0, 5)];
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
        txn_write(a, 8'($urandom), int'($urandom_range(1, 3)), 1'b1, -1);
      end else begin
        txn_read(a, int'($urandom_range(1, 3)));
        txn_stop();
      end
    end

    ack = 1'b0;
    post("pending_writes", exp_wr.size(), 0);
    post("pending_reads", exp_rd.size() + 32'(ack), 0);
    tick(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
